// File: rtl/target_pkg.sv
// Shared types and defaults for the colour-blob target locator.
package target_pkg;

  localparam int IMG_W_DEF     = 320;
  localparam int IMG_H_DEF     = 240;
  localparam int MIN_COUNT_DEF = 64;

  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int CNT_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REPORT
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x_min;
    logic [X_W-1:0] x_max;
    logic [Y_W-1:0] y_min;
    logic [Y_W-1:0] y_max;
  } bbox_t;

  // min at all-ones and max at zero, so the first hit sets all four
  localparam bbox_t BBOX_INIT = {
    {X_W{1'b1}}, {X_W{1'b0}},
    {Y_W{1'b1}}, {Y_W{1'b0}}
  };

  function automatic logic [X_W-1:0] mid_x(
    input logic [X_W-1:0] a,
    input logic [X_W-1:0] b
  );
    logic [X_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[X_W:1];
  endfunction

  function automatic logic [Y_W-1:0] mid_y(
    input logic [Y_W-1:0] a,
    input logic [Y_W-1:0] b
  );
    logic [Y_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[Y_W:1];
  endfunction

endpackage

// File: rtl/pixel_xy_counter.sv
// Raster position counter; clear+advance together lands on the
// position after (0,0), since the clearing beat is pixel (0,0).
module pixel_xy_counter
  import target_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_pixel
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [X_W-1:0] w_xb;
  logic [Y_W-1:0] w_yb;

  always_comb begin
    w_xb = clear ? '0 : r_x;
    w_yb = clear ? '0 : r_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (advance) begin
      if (w_xb == X_LAST) begin
        r_x <= '0;
        r_y <= (w_yb == Y_LAST) ? '0 : w_yb + 1'b1;
      end else begin
        r_x <= w_xb + 1'b1;
        r_y <= w_yb;
      end
    end else if (clear) begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign last_pixel = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/target_locator.sv
// Per-frame bounding box, centre and pixel count of
// colour-matched pixels in a raster pixel stream.
module target_locator
  import target_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int MIN_COUNT = MIN_COUNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             pix_sop,
  input  logic             pix_eop,
  input  logic             is_target,
  output logic             result_valid,
  output logic             target_found,
  output logic [X_W-1:0]   x_min,
  output logic [X_W-1:0]   x_max,
  output logic [X_W-1:0]   x_centre,
  output logic [Y_W-1:0]   y_min,
  output logic [Y_W-1:0]   y_max,
  output logic [Y_W-1:0]   y_centre,
  output logic [CNT_W-1:0] pixel_count,
  output logic             frame_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);
  localparam logic ONE_PIX = (IMG_W == 1) && (IMG_H == 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  bbox_t            r_bb;
  logic             r_full;
  logic             r_ovr;
  logic             r_abort;

  logic [X_W-1:0]   w_x;
  logic [Y_W-1:0]   w_y;
  logic             w_last_c;
  logic             w_sop;
  logic             w_eop_done;
  logic             w_take;
  logic [X_W-1:0]   w_px;
  logic [Y_W-1:0]   w_py;
  logic             w_lastp;
  logic [CNT_W-1:0] w_cnt_n;
  bbox_t            w_bb_n;
  logic             w_full_n;
  logic             w_ovr_n;
  logic             w_abort_n;
  logic             w_found;
  logic             w_err;

  pixel_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_xy (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_sop),
    .advance    (w_take),
    .x          (w_x),
    .y          (w_y),
    .last_pixel (w_last_c)
  );

  assign w_sop = pix_valid & pix_sop;
  assign w_eop_done = pix_valid & pix_eop &
                      (pix_sop | (r_state == ACCUM));
  // sop inside a frame poisons the report of the restarted frame
  assign w_abort_n = w_sop ? (r_state == ACCUM) : r_abort;

  always_comb begin
    w_take   = 1'b0;
    w_px     = w_x;
    w_py     = w_y;
    w_lastp  = w_last_c;
    w_cnt_n  = r_cnt;
    w_bb_n   = r_bb;
    w_full_n = r_full;
    w_ovr_n  = r_ovr;
    if (w_sop) begin
      w_take   = 1'b1;
      w_px     = '0;
      w_py     = '0;
      w_lastp  = ONE_PIX;
      w_cnt_n  = '0;
      w_bb_n   = BBOX_INIT;
      w_full_n = 1'b0;
      w_ovr_n  = 1'b0;
    end else if (r_state == ACCUM && pix_valid) begin
      if (r_full) w_ovr_n = 1'b1;
      else        w_take  = 1'b1;
    end
    if (w_take) begin
      if (is_target) begin
        if (w_cnt_n != CNT_MAX) w_cnt_n = w_cnt_n + 1'b1;
        if (w_px < w_bb_n.x_min) w_bb_n.x_min = w_px;
        if (w_px > w_bb_n.x_max) w_bb_n.x_max = w_px;
        if (w_py < w_bb_n.y_min) w_bb_n.y_min = w_py;
        if (w_py > w_bb_n.y_max) w_bb_n.y_max = w_py;
      end
      if (w_lastp) w_full_n = 1'b1;
    end
  end

  assign w_found = (w_cnt_n >= MIN_CNT);
  assign w_err   = w_ovr_n | w_abort_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bb         <= BBOX_INIT;
      r_full       <= 1'b0;
      r_ovr        <= 1'b0;
      r_abort      <= 1'b0;
      result_valid <= 1'b0;
      target_found <= 1'b0;
      x_min        <= '0;
      x_max        <= '0;
      x_centre     <= '0;
      y_min        <= '0;
      y_max        <= '0;
      y_centre     <= '0;
      pixel_count  <= '0;
      frame_error  <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_n;
      r_bb         <= w_bb_n;
      r_full       <= w_full_n;
      r_ovr        <= w_ovr_n;
      r_abort      <= w_abort_n;
      result_valid <= w_eop_done;

      unique case (r_state)
        IDLE, REPORT: begin
          if (w_sop) r_state <= pix_eop ? REPORT : ACCUM;
          else       r_state <= IDLE;
        end
        ACCUM: begin
          if (w_eop_done) r_state <= REPORT;
        end
        default: r_state <= IDLE;
      endcase

      // results land on the eop edge so they are visible in REPORT
      if (w_eop_done) begin
        pixel_count  <= w_cnt_n;
        target_found <= w_found;
        frame_error  <= w_err;
        if (w_found) begin
          x_min    <= w_bb_n.x_min;
          x_max    <= w_bb_n.x_max;
          x_centre <= mid_x(w_bb_n.x_min, w_bb_n.x_max);
          y_min    <= w_bb_n.y_min;
          y_max    <= w_bb_n.y_max;
          y_centre <= mid_y(w_bb_n.y_min, w_bb_n.y_max);
        end else begin
          x_min    <= '0;
          x_max    <= '0;
          x_centre <= '0;
          y_min    <= '0;
          y_max    <= '0;
          y_centre <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_target_locator.sv
// Scoreboard bench for target_locator on a reduced 40x30 raster,
// two instances differing only in MIN_COUNT.
module tb_target_locator;
  import target_pkg::*;

  localparam int W    = 40;
  localparam int H    = 30;
  localparam int MINA = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_sop = 1'b0;
  logic pix_eop = 1'b0;
  logic is_target = 1'b0;

  logic rv0, f0, fe0, rv1, f1, fe1;
  logic [X_W-1:0] xmn0, xmx0, xc0, xmn1, xmx1, xc1;
  logic [Y_W-1:0] ymn0, ymx0, yc0, ymn1, ymx1, yc1;
  logic [CNT_W-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  target_locator #(.IMG_W(W), .IMG_H(H), .MIN_COUNT(MINA)) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid),
    .pix_sop(pix_sop), .pix_eop(pix_eop), .is_target(is_target),
    .result_valid(rv0), .target_found(f0),
    .x_min(xmn0), .x_max(xmx0), .x_centre(xc0),
    .y_min(ymn0), .y_max(ymx0), .y_centre(yc0),
    .pixel_count(cnt0), .frame_error(fe0)
  );

  target_locator #(.IMG_W(W), .IMG_H(H), .MIN_COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid),
    .pix_sop(pix_sop), .pix_eop(pix_eop), .is_target(is_target),
    .result_valid(rv1), .target_found(f1),
    .x_min(xmn1), .x_max(xmx1), .x_centre(xc1),
    .y_min(ymn1), .y_max(ymx1), .y_centre(yc1),
    .pixel_count(cnt1), .frame_error(fe1)
  );

  typedef struct {
    int found; int cnt;
    int xmin; int xmax; int xc;
    int ymin; int ymax; int yc;
    int err; int cyc;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  res_t g0, g1;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic cmp_res(input string who, input res_t g, input res_t e);
    check({who, ".found"}, g.found, e.found);
    check({who, ".count"}, g.cnt, e.cnt);
    check({who, ".xmin"}, g.xmin, e.xmin);
    check({who, ".xmax"}, g.xmax, e.xmax);
    check({who, ".xc"}, g.xc, e.xc);
    check({who, ".ymin"}, g.ymin, e.ymin);
    check({who, ".ymax"}, g.ymax, e.ymax);
    check({who, ".yc"}, g.yc, e.yc);
    check({who, ".err"}, g.err, e.err);
    check({who, ".lat"}, g.cyc, e.cyc);
  endtask

  function automatic res_t mk(
    input logic f, input logic [CNT_W-1:0] c,
    input logic [X_W-1:0] a, input logic [X_W-1:0] b,
    input logic [X_W-1:0] m, input logic [Y_W-1:0] p,
    input logic [Y_W-1:0] q, input logic [Y_W-1:0] n,
    input logic e, input int cy
  );
    res_t r;
    r.found = int'(f); r.cnt = int'(c);
    r.xmin = int'(a); r.xmax = int'(b); r.xc = int'(m);
    r.ymin = int'(p); r.ymax = int'(q); r.yc = int'(n);
    r.err = int'(e); r.cyc = cy;
    return r;
  endfunction

  function automatic res_t expect_res(
    input int minc, input int cnt,
    input int xa, input int xb, input int ya, input int yb,
    input int err, input int cy
  );
    res_t r;
    r.found = (cnt >= minc) ? 1 : 0;
    r.cnt = cnt;
    r.xmin = 0; r.xmax = 0; r.xc = 0;
    r.ymin = 0; r.ymax = 0; r.yc = 0;
    if (r.found == 1) begin
      r.xmin = xa; r.xmax = xb; r.xc = (xa + xb) / 2;
      r.ymin = ya; r.ymax = yb; r.yc = (ya + yb) / 2;
    end
    r.err = err;
    r.cyc = cy;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rv0) begin
      g0 = mk(f0, cnt0, xmn0, xmx0, xc0, ymn0, ymx0, yc0, fe0, cyc);
      if (q0.size() == 0) check("d0.extra", 1, 0);
      else cmp_res("d0", g0, q0.pop_front());
    end
    if (rv1) begin
      g1 = mk(f1, cnt1, xmn1, xmx1, xc1, ymn1, ymx1, yc1, fe1, cyc);
      if (q1.size() == 0) check("d1.extra", 1, 0);
      else cmp_res("d1", g1, q1.pop_front());
    end
  end

  function automatic bit tgt(input int mode, input int x, input int y);
    case (mode)
      0: return (x >= 10 && x <= 19 && y >= 5 && y <= 14);
      1: return (y == 7 && x >= 10 && x <= 19);
      2: return (x == W - 1 && y == H - 1);
      4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input bit v, input bit s, input bit e, input bit t);
    @(posedge clk);
    #1;
    pix_valid = v;
    pix_sop = s;
    pix_eop = e;
    is_target = t;
  endtask

  // invalid beat with junk on the qualified lines
  task automatic idle();
    drive(1'b0, 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
  endtask

  task automatic send_frame(
    input int nb, input int mode, input bit gaps,
    input bit eop_end, input int err_in
  );
    int cnt = 0;
    int xa = 1000;
    int xb = -1;
    int ya = 1000;
    int yb = -1;
    int ovr = 0;
    for (int i = 0; i < nb; i++) begin
      int x;
      int y;
      bit t;
      if (gaps)
        while ($urandom_range(1, 0) == 1) idle();
      if (i < W * H) begin
        x = i % W;
        y = i / W;
        t = tgt(mode, x, y);
        if (t) begin
          cnt++;
          if (x < xa) xa = x;
          if (x > xb) xb = x;
          if (y < ya) ya = y;
          if (y > yb) yb = y;
        end
      end else begin
        t = 1'b1;
        ovr = 1;
      end
      drive(1'b1, i == 0, eop_end && (i == nb - 1), t);
    end
    if (eop_end) begin
      q0.push_back(expect_res(MINA, cnt, xa, xb, ya, yb,
                              ovr | err_in, cyc + 1));
      q1.push_back(expect_res(1, cnt, xa, xb, ya, yb,
                              ovr | err_in, cyc + 1));
    end
    idle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rv0"}, int'(rv0), 0);
    check({tag, ".cnt0"}, int'(cnt0), 0);
    check({tag, ".f1"}, int'(f1), 0);
    check({tag, ".cnt1"}, int'(cnt1), 0);
    check({tag, ".xmx1"}, int'(xmx1), 0);
    check({tag, ".yc1"}, int'(yc1), 0);
    check({tag, ".fe0"}, int'(fe0), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #12;
    check_zero("rst");
    repeat (2) idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) idle();
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) idle();

    send_frame(W * H, 0, 1'b0, 1'b1, 0);
    repeat (3) idle();
    send_frame(W * H, 1, 1'b0, 1'b1, 0);
    send_frame(W * H, 0, 1'b1, 1'b1, 0);
    send_frame(500, 0, 1'b0, 1'b0, 0);
    send_frame(W * H, 1, 1'b0, 1'b1, 1);
    send_frame(W * H + 10, 4, 1'b0, 1'b1, 0);
    send_frame(1, 4, 1'b0, 1'b1, 0);
    repeat (3) idle();

    send_frame(300, 2, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_zero("midrst");
    repeat (3) idle();
    rst_n = 1'b1;
    repeat (2) idle();
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) idle();
    send_frame(W * H, 2, 1'b0, 1'b1, 0);

    repeat (6) idle();
    check("q0.left", q0.size(), 0);
    check("q1.left", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/target_locator.md
TARGET_LOCATOR -- requirements
Module: target_locator

Interface
REQ-001 Parameter IMG_W, default 320, active pixels per line.
REQ-002 Parameter IMG_H, default 240, active lines per frame.
REQ-003 Parameter MIN_COUNT, default 64, minimum matching pixels for a valid target.
REQ-004 clk  input  1  single clock for the whole block.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 pix_valid  input  1  one pixel beat present this cycle.
REQ-007 pix_sop  input  1  beat is first pixel of frame (x=0, y=0); qualified by pix_valid.
REQ-008 pix_eop  input  1  beat is last pixel of frame; qualified by pix_valid.
REQ-009 is_target  input  1  per-pixel colour-match flag from the colour detector, aligned with pix_valid.
REQ-010 result_valid  output  1  one-cycle pulse, new frame result on outputs.
REQ-011 target_found  output  1  pixel_count >= MIN_COUNT for last reported frame.
REQ-012 x_min, x_max, x_centre  output  9 each  bounding-box columns and centre column.
REQ-013 y_min, y_max, y_centre  output  8 each  bounding-box rows and centre row.
REQ-014 pixel_count  output  17  matching pixels in last frame, saturating at 2^17-1.
REQ-015 frame_error  output  1  last frame overran IMG_W*IMG_H beats or had sop inside a frame.

Function
REQ-016 FSM states IDLE, ACCUM, REPORT; enum in shared package.
REQ-017 IDLE: beats ignored unless pix_valid&pix_sop; that beat enters ACCUM and is processed as pixel (0,0).
REQ-018 ACCUM: every pix_valid beat is processed at current (x,y); x increments, wraps IMG_W-1 -> 0 with y increment.
REQ-019 Processing a beat with is_target=1: pixel_count += 1 (saturating); x_min/x_max/y_min/y_max running values updated by compare.
REQ-020 Running bbox initialises per frame to min=all-ones, max=0 so first match sets all four.
REQ-021 Beats arriving after position (IMG_W-1, IMG_H-1) and before eop are discarded and set an internal overrun flag.
REQ-022 pix_valid&pix_sop in ACCUM: current frame aborted with no report, frame_error latched for the next report, accumulation restarts at (0,0) with this beat.
REQ-023 pix_valid&pix_eop in ACCUM: beat processed, state -> REPORT; eop with sop on same beat is treated as a single-pixel frame.
REQ-024 REPORT lasts exactly one cycle, result_valid=1, then IDLE; latency eop beat -> result_valid is 1 cycle.
REQ-025 In REPORT, outputs load: pixel_count, target_found, frame_error (overrun or aborted-frame flag), and bbox/centres.
REQ-026 Centre = (min+max)>>1 computed at width+1 bits, no truncation before shift.
REQ-027 If target_found=0, all bbox and centre outputs load 0.
REQ-028 Outputs hold between reports; result_valid=0 outside REPORT.
REQ-029 pix_valid=0 cycles in ACCUM cause no state or counter change.
REQ-030 A beat arriving in REPORT is ignored unless sop, which is accepted as in REQ-017.

Reset
REQ-031 rst_n low asynchronously forces IDLE, all outputs 0, counters 0, running bbox to init values, error flags cleared.
REQ-032 Reset mid-frame discards the partial frame; no result_valid until a full sop..eop frame completes.

Structure
REQ-033 Package target_pkg holds IMG_W, IMG_H defaults, coordinate widths (9, 8), count width 17, and the state enum.
REQ-034 One sub-module pixel_xy_counter (clear, advance, x, y, last_pixel) generates coordinates; remainder in target_locator.

Verification
REQ-035 320x240 frame, is_target=1 only for x 100..119, y 50..69 -> pixel_count=400, found=1, x 100/119 centre 109, y 50/69 centre 59, result_valid 1 cycle after eop.
REQ-036 Same frame with 10 matching pixels, MIN_COUNT=64 -> found=0, all coords 0, pixel_count=10.
REQ-037 Random pix_valid gaps (50% duty) on REQ-035 frame -> identical results.
REQ-038 sop reasserted at beat 5000 of a frame, then full frame -> one report only, frame_error=1, results from second frame.
REQ-039 Frame with 76810 beats before eop -> frame_error=1, extra beats excluded from counts.
REQ-040 rst_n low at beat 30000, then full frame with single match at (319,239) -> no report before new frame; then count=1 (MIN_COUNT=1), centre (319,239).
